// File: rtl/quad_decoder_array_if.sv
// Register bus between quad_decoder_array and the system bus: address and
// strobes in, registered read data and valid pulse out.
interface quad_decoder_array_if;
   logic [3:0]  iADDRESS;
   logic        iREAD;
   logic        iWRITE;
   logic [31:0] iWRITE_DATA;
   logic [31:0] oREAD_DATA;
   logic        oREAD_VALID;

   modport master (
      output iADDRESS, iREAD, iWRITE, iWRITE_DATA,
      input  oREAD_DATA, oREAD_VALID
   );

   modport slave (
      input  iADDRESS, iREAD, iWRITE, iWRITE_DATA,
      output oREAD_DATA, oREAD_VALID
   );
endinterface

// File: rtl/quad_decoder_array.sv
// Multi-channel x4 quadrature decoder: synchronise, tick-sample and debounce A/B,
// count a signed wrapping position, expose COUNT/STATUS registers per channel.
module quad_decoder_array #(
   parameter int pENCODERS       = 2,
   parameter int pCNT_BITS       = 16,
   parameter int pPRESCALER_BITS = 6,
   parameter int pFILTER         = 2
) (
   input  logic                 iCLK,
   input  logic                 iRESETn,
   input  logic [pENCODERS-1:0] iENC_A,
   input  logic [pENCODERS-1:0] iENC_B,
   quad_decoder_array_if.slave  bus
);
   localparam int FILT_BITS = 4;
   localparam logic [FILT_BITS-1:0]        FILT_LAST = FILT_BITS'(pFILTER - 1);
   localparam logic signed [pCNT_BITS-1:0] CNT_ONE   = {{(pCNT_BITS-1){1'b0}}, 1'b1};
   localparam logic signed [pCNT_BITS-1:0] CNT_MAX   = {1'b0, {(pCNT_BITS-1){1'b1}}};
   localparam logic signed [pCNT_BITS-1:0] CNT_MIN   = {1'b1, {(pCNT_BITS-1){1'b0}}};

   logic [pPRESCALER_BITS-1:0] presc_reg;
   logic [1:0]                 sync_fill_reg;
   logic                       tick;
   logic [2:0]                 bus_ch;
   logic [31:0]                count_all  [pENCODERS];
   logic [31:0]                status_all [pENCODERS];
   logic [31:0]                rd_data_reg, rd_data_next;
   logic                       rd_valid_reg;
   logic                       unused_write_bits;

   assign bus_ch            = bus.iADDRESS[3:1];
   assign unused_write_bits = ^bus.iWRITE_DATA;

   // Ticks are held off until both synchroniser stages carry real pin samples,
   // so the priming tick never loads the post-reset zeros.
   assign tick = (presc_reg == '0) && sync_fill_reg[1];

   always_ff @(posedge iCLK or negedge iRESETn) begin
      if (!iRESETn) begin
         presc_reg     <= '0;
         sync_fill_reg <= '0;
      end else begin
         presc_reg     <= presc_reg + 1'b1;
         sync_fill_reg <= {sync_fill_reg[0], 1'b1};
      end
   end

   // Position of an {A,B} pair along the forward sequence 00,10,11,01.
   function automatic logic [1:0] phase_of(input logic [1:0] ab);
      case (ab)
         2'b00:   return 2'd0;
         2'b10:   return 2'd1;
         2'b11:   return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < pENCODERS; gi++) begin : g_ch
         logic [1:0]                 sync1_reg, sync2_reg;
         logic [1:0]                 filt_reg, filt_next;
         logic [1:0][FILT_BITS-1:0]  cand_reg, cand_next;
         logic                       primed_reg, primed_next;
         logic signed [pCNT_BITS-1:0] cnt_reg, cnt_next;
         logic                       err_reg, err_next;
         logic                       ovf_reg, ovf_next;
         logic                       dir_reg, dir_next;
         logic [1:0]                 phase_diff;
         logic                       step_up, step_dn, err_evt, ovf_evt;
         logic                       wr_count, wr_status;

         assign wr_count  = bus.iWRITE && (bus_ch == 3'(gi)) && !bus.iADDRESS[0];
         assign wr_status = bus.iWRITE && (bus_ch == 3'(gi)) &&  bus.iADDRESS[0];

         always_comb begin
            filt_next   = filt_reg;
            cand_next   = cand_reg;
            primed_next = primed_reg;
            if (tick) begin
               if (!primed_reg) begin
                  filt_next   = sync2_reg;
                  cand_next   = '0;
                  primed_next = 1'b1;
               end else begin
                  for (int bi = 0; bi < 2; bi++) begin
                     if (sync2_reg[bi] == filt_reg[bi]) begin
                        cand_next[bi] = '0;
                     end else if (cand_reg[bi] == FILT_LAST) begin
                        filt_next[bi] = sync2_reg[bi];
                        cand_next[bi] = '0;
                     end else begin
                        cand_next[bi] = cand_reg[bi] + 1'b1;
                     end
                  end
               end
            end
         end

         // A jump of two positions means both phases moved in one acceptance.
         assign phase_diff = phase_of(filt_next) - phase_of(filt_reg);
         assign step_up    = primed_reg && (phase_diff == 2'd1);
         assign step_dn    = primed_reg && (phase_diff == 2'd3);
         assign err_evt    = primed_reg && (phase_diff == 2'd2);

         always_comb begin
            cnt_next = cnt_reg;
            dir_next = dir_reg;
            err_next = err_reg;
            ovf_next = ovf_reg;
            ovf_evt  = 1'b0;
            if (wr_count) begin
               cnt_next = bus.iWRITE_DATA[pCNT_BITS-1:0];
            end else if (step_up) begin
               cnt_next = cnt_reg + CNT_ONE;
               dir_next = 1'b1;
               ovf_evt  = (cnt_reg == CNT_MAX);
            end else if (step_dn) begin
               cnt_next = cnt_reg - CNT_ONE;
               dir_next = 1'b0;
               ovf_evt  = (cnt_reg == CNT_MIN);
            end
            if (wr_status) begin
               err_next = err_reg & ~bus.iWRITE_DATA[0];
               ovf_next = ovf_reg & ~bus.iWRITE_DATA[1];
            end
            if (err_evt) err_next = 1'b1;
            if (ovf_evt) ovf_next = 1'b1;
         end

         always_ff @(posedge iCLK or negedge iRESETn) begin
            if (!iRESETn) begin
               sync1_reg  <= '0;
               sync2_reg  <= '0;
               filt_reg   <= '0;
               cand_reg   <= '0;
               primed_reg <= 1'b0;
               cnt_reg    <= '0;
               err_reg    <= 1'b0;
               ovf_reg    <= 1'b0;
               dir_reg    <= 1'b0;
            end else begin
               sync1_reg  <= {iENC_A[gi], iENC_B[gi]};
               sync2_reg  <= sync1_reg;
               filt_reg   <= filt_next;
               cand_reg   <= cand_next;
               primed_reg <= primed_next;
               cnt_reg    <= cnt_next;
               err_reg    <= err_next;
               ovf_reg    <= ovf_next;
               dir_reg    <= dir_next;
            end
         end

         assign count_all[gi]  = 32'(cnt_reg);
         assign status_all[gi] = {26'd0, primed_reg, dir_reg, filt_reg, ovf_reg, err_reg};
      end
   endgenerate

   always_comb begin
      rd_data_next = '0;
      for (int ci = 0; ci < pENCODERS; ci++) begin
         if (bus_ch == 3'(ci)) begin
            rd_data_next = bus.iADDRESS[0] ? status_all[ci] : count_all[ci];
         end
      end
   end

   always_ff @(posedge iCLK or negedge iRESETn) begin
      if (!iRESETn) begin
         rd_data_reg  <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         rd_valid_reg <= bus.iREAD;
         if (bus.iREAD) rd_data_reg <= rd_data_next;
      end
   end

   assign bus.oREAD_DATA  = rd_data_reg;
   assign bus.oREAD_VALID = rd_valid_reg;
endmodule

// File: doc/quad_decoder_array.md
# quad_decoder_array

Multi-channel quadrature encoder decoder with a register read/write interface for the MKR pin fabric. Each of `pENCODERS` channels does the following:
- synchronises its A/B inputs;
- samples them on a shared prescaled tick and debounces them;
- decodes x4 quadrature into a signed wrapping position counter;
- keeps sticky error and overflow flags.

The block sits between the SAM/PEX pin inputs and the system bus as a memory-mapped peripheral. It is the parametrised replacement for the fixed two-channel, 16-bit decoder.

## Interface
Parameters:
- `pENCODERS`, 2, number of channels (1..8)
- `pCNT_BITS`, 16, position counter width (2..32)
- `pPRESCALER_BITS`, 6, sample tick period is 2^pPRESCALER_BITS clocks
- `pFILTER`, 2, consecutive equal ticks needed to accept a new input level (1..15)

Ports:
- `iCLK`  in  1  system clock
- `iRESETn`  in  1  reset; one clock, reset is asynchronous and active-low
- `iENC_A`  in  pENCODERS  encoder phase A, asynchronous
- `iENC_B`  in  pENCODERS  encoder phase B, asynchronous
- `iADDRESS`  in  4  `[3:1]` = channel, `[0]`: 0 = COUNT, 1 = STATUS
- `iREAD`  in  1  read strobe, one cycle
- `iWRITE`  in  1  write strobe, one cycle
- `iWRITE_DATA`  in  32  write data
- `oREAD_DATA`  out  32  registered read data
- `oREAD_VALID`  out  1  read data valid pulse

## Operation
- **Synchronisers:** 2-flop synchroniser per A/B bit, clocked every cycle.
- **Prescaler:** free-running `pPRESCALER_BITS` counter; tick = (prescaler == 0).
- **Filter:** per input bit, a candidate counter.
  - On a tick, if the synced level differs from the filtered level, the counter increments; otherwise it clears.
  - When the count reaches `pFILTER`, the filtered level takes the synced level and the counter clears.
- **Priming:** per-channel primed bit.
  - The first tick after reset loads the filtered {A,B} directly from the synced values and sets primed.
  - The priming tick generates no step and no error.
- **Decode:** compare old vs new filtered {A,B} on each acceptance.
  - Forward sequence 00→10→11→01→00: +1, DIR=1.
  - Reverse sequence: −1, DIR=0.
  - No change: nothing.
  - Both bits changed in one acceptance: set ERR, no count change.
- **Counter:** `pCNT_BITS` two's complement, wraps.
  - OVF sets on +1 from max positive to min negative, or −1 from min negative to max positive.
- **COUNT register:**
  - Read returns the counter sign-extended to 32 bits.
  - Write loads `iWRITE_DATA[pCNT_BITS-1:0]`.
- **STATUS register:**
  - bit0 ERR (sticky); bit1 OVF (sticky); bits3:2 filtered {A,B}; bit4 DIR of last step; bit5 primed; others 0.
  - Write: W1C on bits 0..1; other bits ignored.
- **Unmapped channels:** channel ≥ `pENCODERS` reads 0; writes are ignored.
- **Collisions:**
  - COUNT write and step in the same cycle: the write wins and the step is dropped.
  - W1C and a new ERR/OVF event in the same cycle: set wins.
  - Read and write in the same cycle to the same register: the read returns the pre-write value.
- **Reset (async assert, any time including mid-step):** all of the following go to 0 immediately:
  - counters, flags, DIR, primed, filters, synchronisers, prescaler;
  - `oREAD_DATA` and `oREAD_VALID`.
- **Simultaneous iREAD and iWRITE:** both are serviced.

## Timing
- Read latency is 1 cycle: `oREAD_DATA` valid and `oREAD_VALID` high in the cycle after `iREAD`. `oREAD_DATA` holds until the next read.
- Writes take effect at the clock edge where `iWRITE` is sampled.
- Input to count: 2 sync cycles + `pFILTER` ticks. Worst case is 2 + `pFILTER`·2^`pPRESCALER_BITS` + 1 cycles.
- The counter and flags update at the same edge as filter acceptance and are visible to a read issued on the next cycle.
- Maximum trackable edge rate: one state change per `pFILTER` ticks per phase.

## Test plan
All scenarios use `pPRESCALER_BITS`=2, `pFILTER`=2, `pENCODERS`=2.
- **Priming:** hold A=B=1 through reset release, wait 20 cycles → COUNT0 = 0x00000000, STATUS0 = 0x2C (primed, AB=11), ERR=0.
- **Forward counting:** 8 forward cycles on ch0, each state held 16 clocks → COUNT0 = 0x00000020, COUNT1 = 0, STATUS0 bit4 = 1.
- **Reverse counting:** from 0, 3 reverse steps on ch1 → COUNT1 = 0xFFFFFFFD, DIR=0.
- **Glitch rejection:** 4-clock (single-tick) pulse on A0 → COUNT0 unchanged.
- **Simultaneous change:** toggle A0 and B0 together → ERR=1, count unchanged. Write STATUS0 = 0x1 → ERR=0. Repeat with the toggle landing on the same cycle as the W1C → ERR stays 1.
- **Overflow and reset:**
  - Write COUNT0 = 0x7FFF, then one forward step → COUNT0 reads 0xFFFF8000, OVF=1.
  - Assert `iRESETn` low mid-step → `oREAD_VALID`=0 and all counts 0 immediately, without waiting for a clock edge.
